sdcard_spi_engine: RTL and testbench

Parametrised SPI master engine for the SD-card interface: clocks bursts of 1..2^CNT_WIDTH words of WORD_BITS each, with programmable SCLK divider and clock polarity.
Adds a response-hunt mode: MOSI held high while MISO is clocked until the first 0 bit, which becomes the MSB of the first received word, bounded by a bit limit.
Sits between the SD-card command/data sequencer (via start/tx/rx strobes) and the card pins.

---
 rtl/sdcard_spi_engine.sv | 188 ++++++++++++++++++
 tb/tb_sdcard_spi_engine.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdcard_spi_engine.sv
// SPI master engine for the SD-card interface.
// Clocks bursts of (count+1) words of WORD_BITS bits, MSB first, CPHA=0, with a
// programmable SCLK half-period and idle polarity. In response-hunt mode MOSI is
// held high while MISO is clocked until the first 0 bit, which becomes the MSB
// of the first received word; too many leading 1 bits end the burst with timeout.
//
// Ports:
//   clk, rst              system clock, asynchronous active-high reset
//   sclk, mosi, miso      card pins
//   divider, cpol, hunt,  transfer configuration, latched at start
//   hunt_limit, count
//   start                 one-cycle request, ignored while busy
//   tx_data / tx_load     transmit word and its sample strobe
//   rx_data / rx_valid    last received word and its update strobe
//   busy, done, timeout   transfer status
module sdcard_spi_engine #(
   parameter int unsigned DIV_WIDTH  = 8,
   parameter int unsigned WORD_BITS  = 8,
   parameter int unsigned CNT_WIDTH  = 10,
   parameter int unsigned HUNT_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  sclk,
   output logic                  mosi,
   input  logic                  miso,
   input  logic [DIV_WIDTH-1:0]  divider,
   input  logic                  cpol,
   input  logic                  hunt,
   input  logic [HUNT_WIDTH-1:0] hunt_limit,
   input  logic [CNT_WIDTH-1:0]  count,
   input  logic                  start,
   input  logic [WORD_BITS-1:0]  tx_data,
   output logic                  tx_load,
   output logic [WORD_BITS-1:0]  rx_data,
   output logic                  rx_valid,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout
);

   localparam int unsigned BitW = $clog2(WORD_BITS + 1);
   localparam logic [BitW-1:0] WordLast = BitW'(WORD_BITS);

   typedef enum logic [1:0] {StIdle, StHunt, StShift, StFinish} state_e;

   state_e                state_q;
   logic [DIV_WIDTH-1:0]  div_q;
   logic [DIV_WIDTH-1:0]  tick_cnt_q;
   logic                  cpol_q;
   logic                  hunt_q;
   logic [HUNT_WIDTH-1:0] limit_q;
   logic [HUNT_WIDTH:0]   hunt_cnt_q;
   logic                  hunt_to_q;
   logic [CNT_WIDTH-1:0]  wcnt_q;
   logic [BitW-1:0]       bit_cnt_q;
   logic                  trail_q;     // next tick is the trailing edge of a bit
   logic [WORD_BITS-1:0]  tx_sr_q;
   logic [WORD_BITS-1:0]  rx_sr_q;
   logic                  sclk_q;
   logic [WORD_BITS-1:0]  rx_data_q;
   logic                  rx_valid_q;
   logic                  done_q;
   logic                  timeout_q;

   logic                  active;
   logic                  tick;
   logic                  word_end;
   logic [HUNT_WIDTH:0]   hunt_next;

   assign active    = (state_q == StHunt) || (state_q == StShift);
   assign tick      = active && (tick_cnt_q == div_q);
   assign word_end  = (state_q == StShift) && tick && trail_q && (bit_cnt_q == WordLast);
   assign hunt_next = hunt_cnt_q + 1'b1;

   // tx_load is combinational so the sequencer sees it in the cycle tx_data is sampled.
   assign tx_load  = ((state_q == StIdle) && start && !hunt) ||
                     (word_end && (wcnt_q != '0) && !hunt_q);
   assign mosi     = (state_q == StShift) ? tx_sr_q[WORD_BITS-1] : 1'b1;
   assign sclk     = sclk_q;
   assign busy     = (state_q != StIdle);
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign done     = done_q;
   assign timeout  = timeout_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         div_q      <= '0;
         tick_cnt_q <= '0;
         cpol_q     <= 1'b0;
         hunt_q     <= 1'b0;
         limit_q    <= '0;
         hunt_cnt_q <= '0;
         hunt_to_q  <= 1'b0;
         wcnt_q     <= '0;
         bit_cnt_q  <= '0;
         trail_q    <= 1'b0;
         tx_sr_q    <= '1;
         rx_sr_q    <= '0;
         sclk_q     <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         rx_valid_q <= 1'b0;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
         case (state_q)
            StIdle: begin
               sclk_q <= cpol;
               if (start) begin
                  div_q      <= divider;
                  cpol_q     <= cpol;
                  hunt_q     <= hunt;
                  limit_q    <= hunt_limit;
                  wcnt_q     <= count;
                  tick_cnt_q <= '0;
                  hunt_cnt_q <= '0;
                  hunt_to_q  <= 1'b0;
                  bit_cnt_q  <= '0;
                  trail_q    <= 1'b0;
                  if (hunt) begin
                     tx_sr_q <= '1;
                     state_q <= StHunt;
                  end else begin
                     tx_sr_q <= tx_data;
                     state_q <= StShift;
                  end
               end
            end
            StHunt, StShift: begin
               tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
               if (tick) begin
                  if (!trail_q) begin
                     // Leading edge: leave idle level, sample MISO.
                     sclk_q  <= ~cpol_q;
                     trail_q <= 1'b1;
                     if (state_q == StHunt) begin
                        if (miso) begin
                           hunt_cnt_q <= hunt_next;
                           // Finish the current bit cleanly; exit on its trailing edge.
                           if (hunt_next >= {1'b0, limit_q}) hunt_to_q <= 1'b1;
                        end else begin
                           rx_sr_q   <= {rx_sr_q[WORD_BITS-2:0], 1'b0};
                           bit_cnt_q <= BitW'(1);
                           state_q   <= StShift;
                        end
                     end else begin
                        rx_sr_q   <= {rx_sr_q[WORD_BITS-2:0], miso};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                     end
                  end else begin
                     // Trailing edge: back to idle level, advance TX.
                     sclk_q  <= cpol_q;
                     trail_q <= 1'b0;
                     if (state_q == StHunt) begin
                        if (hunt_to_q) state_q <= StFinish;
                     end else if (bit_cnt_q == WordLast) begin
                        rx_data_q  <= rx_sr_q;
                        rx_valid_q <= 1'b1;
                        bit_cnt_q  <= '0;
                        if (wcnt_q != '0) begin
                           wcnt_q  <= wcnt_q - 1'b1;
                           tx_sr_q <= hunt_q ? '1 : tx_data;
                        end else begin
                           state_q <= StFinish;
                        end
                     end else begin
                        tx_sr_q <= {tx_sr_q[WORD_BITS-2:0], 1'b1};
                     end
                  end
               end
            end
            StFinish: begin
               sclk_q    <= cpol_q;
               done_q    <= 1'b1;
               timeout_q <= hunt_to_q;
               state_q   <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_sdcard_spi_engine.sv
// Directed bench for sdcard_spi_engine with default parameters (8-bit words).
module tb_sdcard_spi_engine;

   logic       clk = 1'b0;
   logic       rst;
   logic       sclk;
   logic       mosi;
   logic       miso;
   logic [7:0] divider;
   logic       cpol;
   logic       hunt;
   logic [7:0] hunt_limit;
   logic [9:0] count;
   logic       start;
   logic [7:0] tx_data;
   logic       tx_load;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;
   logic       done;
   logic       timeout;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sdcard_spi_engine dut (
      .clk        (clk),
      .rst        (rst),
      .sclk       (sclk),
      .mosi       (mosi),
      .miso       (miso),
      .divider    (divider),
      .cpol       (cpol),
      .hunt       (hunt),
      .hunt_limit (hunt_limit),
      .count      (count),
      .start      (start),
      .tx_data    (tx_data),
      .tx_load    (tx_load),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .busy       (busy),
      .done       (done),
      .timeout    (timeout)
   );

   // Transmit word source, advanced after each tx_load.
   logic [7:0] tx_words [0:7];
   int         tx_idx = 0;
   logic       tx_clr = 1'b0;
   assign tx_data = tx_words[tx_idx[2:0]];
   always @(posedge clk) begin
      if (tx_clr)       tx_idx <= 0;
      else if (tx_load) tx_idx <= tx_idx + 1;
   end

   // MISO: looped back from MOSI, or a bit pattern advanced on each falling SCLK.
   logic        loop_mode = 1'b1;
   logic [31:0] pat_bits = '1;
   int          pat_idx = 0;
   logic        pat_bit;
   always_comb begin
      pat_bit = 1'b1;
      if (pat_idx < 32) pat_bit = pat_bits[31 - pat_idx];
   end
   assign miso = loop_mode ? mosi : pat_bit;
   always @(negedge sclk) pat_idx = pat_idx + 1;

   // Event monitor, sampled on the falling clock edge.
   logic [7:0] rx_q[$];
   int         edge_t[$];
   int         n_txload, n_done, n_to, n_edges, n_mosi0, ncyc;
   logic       sclk_prev;
   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid) rx_q.push_back(rx_data);
         if (tx_load) n_txload++;
         if (done) n_done++;
         if (done && timeout) n_to++;
         if (sclk !== sclk_prev) begin
            n_edges++;
            edge_t.push_back(ncyc);
         end
         if (busy && mosi === 1'b0) n_mosi0++;
         sclk_prev = sclk;
         ncyc++;
      end
   end

   task automatic clear_mon();
      rx_q.delete();
      edge_t.delete();
      n_txload = 0; n_done = 0; n_to = 0; n_edges = 0; n_mosi0 = 0; ncyc = 0;
      sclk_prev = sclk;
      tx_clr = 1'b1;
      @(posedge clk);
      #1 tx_clr = 1'b0;
   endtask

   // Called at posedge+1; returns tx_load seen in the start cycle.
   task automatic pulse_start(output logic tl);
      start = 1'b1;
      #1 tl = tx_load;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input int bound, output int lat, output bit seen);
      seen = 1'b0;
      lat  = 0;
      for (int i = 1; i <= bound && !seen; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            seen = 1'b1;
            lat  = i;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; divider = '0; cpol = 1'b0; hunt = 1'b0;
      hunt_limit = '0; count = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b want 0", sclk); end
      checks++; if (mosi !== 1'b1) begin errors++; $display("FAIL reset_mosi got %b want 1", mosi); end
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
      checks++; if ({tx_load, rx_valid, busy, done, timeout} !== 5'b0) begin
         errors++; $display("FAIL reset_flags got %b want 00000", {tx_load, rx_valid, busy, done, timeout});
      end
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_loopback();
      logic tl; int lat; bit seen;
      loop_mode = 1'b1; divider = 8'd0; cpol = 1'b0; count = '0; hunt = 1'b0;
      tx_words[0] = 8'hA5;
      clear_mon();
      pulse_start(tl);
      checks++; if (tl !== 1'b1) begin errors++; $display("FAIL loop_tx_load got %b want 1", tl); end
      wait_done(200, lat, seen);
      checks++; if (!seen || lat != 17) begin errors++; $display("FAIL loop_latency got %0d (seen %b) want 17", lat, seen); end
      checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL loop_rx_count got %0d want 1", rx_q.size()); end
      else begin
         checks++; if (rx_q[0] !== 8'hA5) begin errors++; $display("FAIL loop_rx_data got %h want a5", rx_q[0]); end
      end
      @(posedge clk); #1;
      checks++; if (n_edges != 16) begin errors++; $display("FAIL loop_sclk_edges got %0d want 16", n_edges); end
      checks++; if (mosi !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL loop_after got mosi=%b busy=%b want mosi=1 busy=0", mosi, busy);
      end
   endtask

   task automatic test_multi();
      logic tl; int lat; bit seen;
      loop_mode = 1'b1; divider = 8'd3; cpol = 1'b1; count = 10'd2; hunt = 1'b0;
      tx_words[0] = 8'h01; tx_words[1] = 8'h80; tx_words[2] = 8'hFF;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL multi_idle_sclk got %b want 1", sclk); end
      clear_mon();
      pulse_start(tl);
      wait_done(1000, lat, seen);
      checks++; if (!seen || lat != 193) begin errors++; $display("FAIL multi_latency got %0d (seen %b) want 193", lat, seen); end
      @(posedge clk); #1;
      checks++; if (n_txload != 3) begin errors++; $display("FAIL multi_tx_load got %0d want 3", n_txload); end
      checks++; if (n_done != 1) begin errors++; $display("FAIL multi_done got %0d want 1", n_done); end
      checks++; if (n_edges != 48) begin errors++; $display("FAIL multi_edges got %0d want 48", n_edges); end
      checks++; if (edge_t.size() < 2 || edge_t[1] - edge_t[0] != 4) begin
         errors++; $display("FAIL multi_half_period got %0d edges want spacing 4", edge_t.size());
      end
      checks++; if (rx_q.size() != 3) begin errors++; $display("FAIL multi_rx_count got %0d want 3", rx_q.size()); end
      else begin
         checks++; if (rx_q[0] !== 8'h01 || rx_q[1] !== 8'h80 || rx_q[2] !== 8'hFF) begin
            errors++; $display("FAIL multi_rx_data got %h %h %h want 01 80 ff", rx_q[0], rx_q[1], rx_q[2]);
         end
      end
      checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL multi_end_sclk got %b want 1", sclk); end
      cpol = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_hunt();
      logic tl; int lat; bit seen;
      loop_mode = 1'b0; divider = 8'd1; cpol = 1'b0; count = '0; hunt = 1'b1;
      hunt_limit = 8'd20;
      clear_mon();
      pat_bits = {5'b11111, 8'h3C, 19'h7FFFF};
      pat_idx = 0;
      pulse_start(tl);
      checks++; if (tl !== 1'b0) begin errors++; $display("FAIL hunt_start_tx_load got %b want 0", tl); end
      wait_done(500, lat, seen);
      checks++; if (!seen || timeout !== 1'b0) begin errors++; $display("FAIL hunt_done got seen=%b timeout=%b want 1 0", seen, timeout); end
      @(posedge clk); #1;
      checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h3C) begin
         errors++; $display("FAIL hunt_rx got %0d words first %h want 1 word 3c", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
      end
      checks++; if (n_mosi0 != 0 || n_txload != 0) begin
         errors++; $display("FAIL hunt_mosi got mosi0=%0d tx_load=%0d want 0 0", n_mosi0, n_txload);
      end
   endtask

   task automatic test_hunt_timeout();
      logic tl; int lat; bit seen;
      loop_mode = 1'b0; divider = 8'd0; cpol = 1'b0; count = '0; hunt = 1'b1;
      hunt_limit = 8'd8;
      clear_mon();
      pat_bits = '1;
      pat_idx = 0;
      pulse_start(tl);
      wait_done(500, lat, seen);
      checks++; if (!seen || timeout !== 1'b1) begin errors++; $display("FAIL to_pulse got seen=%b timeout=%b want 1 1", seen, timeout); end
      @(posedge clk); #1;
      checks++; if (n_edges != 16) begin errors++; $display("FAIL to_edges got %0d want 16", n_edges); end
      checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL to_rx_valid got %0d want 0", rx_q.size()); end
      checks++; if (busy !== 1'b0 || n_to != 1) begin errors++; $display("FAIL to_end got busy=%b n_to=%0d want 0 1", busy, n_to); end
      hunt = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic tl; int lat; bit seen;
      loop_mode = 1'b1; divider = 8'd3; cpol = 1'b0; count = '0; hunt = 1'b0;
      tx_words[0] = 8'hC3; tx_words[1] = 8'h5A;
      clear_mon();
      pulse_start(tl);
      repeat (20) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0 || sclk !== 1'b0 || mosi !== 1'b1) begin
         errors++; $display("FAIL rstmid_outputs got busy=%b sclk=%b mosi=%b want 0 0 1", busy, sclk, mosi);
      end
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_rx_data got %h want 00", rx_data); end
      @(posedge clk);
      #3 rst = 1'b0;
      repeat (60) @(posedge clk);
      #1;
      checks++; if (n_done != 0 || rx_q.size() != 0) begin
         errors++; $display("FAIL rstmid_no_done got done=%0d rx=%0d want 0 0", n_done, rx_q.size());
      end
      divider = 8'd0;
      pulse_start(tl);
      wait_done(200, lat, seen);
      checks++; if (!seen || lat != 17) begin errors++; $display("FAIL rstmid_restart got %0d (seen %b) want 17", lat, seen); end
      @(posedge clk); #1;
      checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h5A) begin
         errors++; $display("FAIL rstmid_rx got %0d words first %h want 1 word 5a", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
      end
   endtask

   task automatic test_back_to_back();
      logic tl; int lat; bit seen;
      loop_mode = 1'b1; divider = 8'd0; cpol = 1'b0; count = '0; hunt = 1'b0;
      tx_words[0] = 8'h33; tx_words[1] = 8'hC3;
      clear_mon();
      pulse_start(tl);
      repeat (4) @(posedge clk);
      #1 count = 10'd2;
      pulse_start(tl);
      count = '0;
      checks++; if (tl !== 1'b0) begin errors++; $display("FAIL b2b_busy_tx_load got %b want 0", tl); end
      wait_done(200, lat, seen);
      checks++; if (!seen || lat != 12) begin errors++; $display("FAIL b2b_first_latency got %0d (seen %b) want 12", lat, seen); end
      pulse_start(tl);
      checks++; if (tl !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL b2b_restart got tx_load=%b busy=%b want 1 1", tl, busy);
      end
      wait_done(200, lat, seen);
      checks++; if (!seen || lat != 17) begin errors++; $display("FAIL b2b_second_latency got %0d (seen %b) want 17", lat, seen); end
      @(posedge clk); #1;
      checks++; if (rx_q.size() != 2 || n_done != 2) begin
         errors++; $display("FAIL b2b_counts got rx=%0d done=%0d want 2 2", rx_q.size(), n_done);
      end
      else begin
         checks++; if (rx_q[0] !== 8'h33 || rx_q[1] !== 8'hC3) begin
            errors++; $display("FAIL b2b_rx got %h %h want 33 c3", rx_q[0], rx_q[1]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_multi();
      test_hunt();
      test_hunt_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
